// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode, state, select encodings and control bundle shared by the control unit and datapath.
package cpu_pkg;
  localparam logic [5:0] op_add   = 6'b000000;
  localparam logic [5:0] op_sub   = 6'b000001;
  localparam logic [5:0] op_addi  = 6'b000010;
  localparam logic [5:0] op_or    = 6'b010000;
  localparam logic [5:0] op_and   = 6'b010001;
  localparam logic [5:0] op_ori   = 6'b010010;
  localparam logic [5:0] op_sll   = 6'b011000;
  localparam logic [5:0] op_slt   = 6'b100110;
  localparam logic [5:0] op_sltiu = 6'b100111;
  localparam logic [5:0] op_sw    = 6'b110000;
  localparam logic [5:0] op_lw    = 6'b110001;
  localparam logic [5:0] op_beq   = 6'b110100;
  localparam logic [5:0] op_bne   = 6'b110101;
  localparam logic [5:0] op_bltz  = 6'b110110;
  localparam logic [5:0] op_j     = 6'b111000;
  localparam logic [5:0] op_jr    = 6'b111001;
  localparam logic [5:0] op_jal   = 6'b111010;
  localparam logic [5:0] op_halt  = 6'b111111;

  localparam logic [2:0] alu_add  = 3'b000;
  localparam logic [2:0] alu_sub  = 3'b001;
  localparam logic [2:0] alu_sll  = 3'b010;
  localparam logic [2:0] alu_or   = 3'b011;
  localparam logic [2:0] alu_and  = 3'b100;
  localparam logic [2:0] alu_sltu = 3'b101;
  localparam logic [2:0] alu_slt  = 3'b110;

  localparam logic [1:0] pc_next   = 2'b00;
  localparam logic [1:0] pc_branch = 2'b01;
  localparam logic [1:0] pc_rs     = 2'b10;
  localparam logic [1:0] pc_jump   = 2'b11;

  localparam logic [1:0] dst_ra = 2'b00;
  localparam logic [1:0] dst_rt = 2'b01;
  localparam logic [1:0] dst_rd = 2'b10;

  typedef enum logic [3:0] {
    s_if, s_id, s_exe_al, s_exe_br, s_exe_ls, s_mem, s_wb_al, s_wb_ld, s_halt
  } state_t;

  typedef enum logic [2:0] {c_al, c_br, c_ls, c_jmp, c_halt} op_class_t;

  typedef struct packed {
    logic       pcwre;
    logic       irwre;
    logic       alusrca;
    logic       alusrcb;
    logic       dbdatasrc;
    logic       regwre;
    logic       wrregdsrc;
    logic       mrd;
    logic       mwr;
    logic       extsel;
    logic [1:0] regdst;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       halted;
  } ctrl_t;

  // Jumps and undefined opcodes share c_jmp: both retire in sID.
  function automatic op_class_t classify(logic [5:0] op);
    return (op inside {op_beq, op_bne, op_bltz}) ? c_br :
           (op inside {op_sw, op_lw}) ? c_ls :
           (op == op_halt) ? c_halt :
           (op inside {op_add, op_sub, op_addi, op_or, op_and, op_ori,
                       op_sll, op_slt, op_sltiu}) ? c_al : c_jmp;
  endfunction
endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: opcode/flags from the datapath and the control signals back to it.
interface multicycle_control_unit_if;
  logic [5:0] opcode;
  logic       zero;
  logic       sign;
  logic       PCWre;
  logic       IRWre;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       DBDataSrc;
  logic       RegWre;
  logic       WrRegDSrc;
  logic       mRD;
  logic       mWR;
  logic       ExtSel;
  logic [1:0] RegDst;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic       halted;
  modport master (
    input  opcode, zero, sign,
    output PCWre, IRWre, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, WrRegDSrc,
           mRD, mWR, ExtSel, RegDst, PCSrc, ALUOp, halted
  );
  modport slave (
    output opcode, zero, sign,
    input  PCWre, IRWre, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, WrRegDSrc,
           mRD, mWR, ExtSel, RegDst, PCSrc, ALUOp, halted
  );
endinterface

// File: rtl/control_decode.sv
// control_decode: combinational map of {state, opcode, zero, sign} to the datapath control bundle.
module control_decode
  import cpu_pkg::*;
(
  input  logic       en,
  input  state_t     st,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output ctrl_t      ctrl
);
  op_class_t cls;
  logic      take;
  ctrl_t     c;
  assign cls = classify(opcode);
  // Flags are only trusted during the branch's own execute cycle.
  assign take = (st == s_exe_br) &&
                ((opcode == op_beq && zero) || (opcode == op_bne && !zero) ||
                 (opcode == op_bltz && sign));
  always_comb begin
    c = '0;
    c.irwre     = st == s_if;
    c.pcwre     = (st == s_id && cls == c_jmp) || st == s_exe_br ||
                  (st == s_mem && opcode == op_sw) || st == s_wb_al || st == s_wb_ld;
    c.regwre    = st == s_wb_al || st == s_wb_ld || (st == s_id && opcode == op_jal);
    c.mwr       = st == s_mem && opcode == op_sw;
    c.mrd       = (st == s_mem || st == s_wb_ld) && opcode == op_lw;
    c.halted    = st == s_halt;
    c.alusrca   = opcode == op_sll;
    c.alusrcb   = opcode inside {op_addi, op_ori, op_sltiu, op_sw, op_lw};
    c.dbdatasrc = opcode == op_lw;
    c.wrregdsrc = opcode != op_jal;
    c.extsel    = !(opcode inside {op_ori, op_sltiu});
    c.regdst    = (opcode inside {op_add, op_sub, op_or, op_and, op_sll, op_slt}) ? dst_rd :
                  (opcode inside {op_addi, op_ori, op_sltiu, op_lw}) ? dst_rt : dst_ra;
    c.pcsrc     = (opcode == op_jr) ? pc_rs :
                  (opcode inside {op_j, op_jal}) ? pc_jump :
                  take ? pc_branch : pc_next;
    c.aluop     = (opcode inside {op_sub, op_beq, op_bne}) ? alu_sub :
                  (opcode == op_sll) ? alu_sll :
                  (opcode inside {op_or, op_ori}) ? alu_or :
                  (opcode == op_and) ? alu_and :
                  (opcode == op_sltiu) ? alu_sltu :
                  (opcode inside {op_slt, op_bltz}) ? alu_slt : alu_add;
    ctrl        = en ? c : '0;
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: IF/ID/EXE/MEM/WB sequencer; state register here, signal decode in control_decode.
module multicycle_control_unit
  import cpu_pkg::*;
(
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);
  state_t    st;
  ctrl_t     ctrl;
  op_class_t cls;
  assign cls = classify(bus.opcode);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= s_if;
    else begin
      case (st)
        s_if:     st <= s_id;
        s_id:     st <= (cls == c_halt) ? s_halt : (cls == c_br) ? s_exe_br :
                        (cls == c_ls) ? s_exe_ls : (cls == c_al) ? s_exe_al : s_if;
        s_exe_al: st <= s_wb_al;
        s_exe_ls: st <= s_mem;
        s_mem:    st <= (bus.opcode == op_lw) ? s_wb_ld : s_if;
        s_halt:   st <= s_halt;
        default:  st <= s_if;
      endcase
    end
  end
  // Decode is gated by rst_n so every enable drops the instant reset asserts.
  control_decode u_dec (
    .en(rst_n), .st(st), .opcode(bus.opcode), .zero(bus.zero), .sign(bus.sign), .ctrl(ctrl)
  );
  assign bus.PCWre     = ctrl.pcwre;
  assign bus.IRWre     = ctrl.irwre;
  assign bus.ALUSrcA   = ctrl.alusrca;
  assign bus.ALUSrcB   = ctrl.alusrcb;
  assign bus.DBDataSrc = ctrl.dbdatasrc;
  assign bus.RegWre    = ctrl.regwre;
  assign bus.WrRegDSrc = ctrl.wrregdsrc;
  assign bus.mRD       = ctrl.mrd;
  assign bus.mWR       = ctrl.mwr;
  assign bus.ExtSel    = ctrl.extsel;
  assign bus.RegDst    = ctrl.regdst;
  assign bus.PCSrc     = ctrl.pcsrc;
  assign bus.ALUOp     = ctrl.aluop;
  assign bus.halted    = ctrl.halted;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed per-cycle vectors pushed to a scoreboard, checked on negedge.
module tb_multicycle_control_unit;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int failures = 0;
  multicycle_control_unit_if bus();
  multicycle_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] v;
    logic [17:0] m;
  } exp_t;
  exp_t q[$];

  localparam logic [11:0] m_a   = 12'b1_0_0_0_0_00_00_000;
  localparam logic [11:0] m_b   = 12'b0_1_0_0_0_00_00_000;
  localparam logic [11:0] m_db  = 12'b0_0_1_0_0_00_00_000;
  localparam logic [11:0] m_wr  = 12'b0_0_0_1_0_00_00_000;
  localparam logic [11:0] m_ext = 12'b0_0_0_0_1_00_00_000;
  localparam logic [11:0] m_dst = 12'b0_0_0_0_0_11_00_000;
  localparam logic [11:0] m_pc  = 12'b0_0_0_0_0_00_11_000;
  localparam logic [11:0] m_op  = 12'b0_0_0_0_0_00_00_111;

  logic [17:0] act;
  assign act = {bus.PCWre, bus.IRWre, bus.RegWre, bus.mRD, bus.mWR, bus.halted,
                bus.ALUSrcA, bus.ALUSrcB, bus.DBDataSrc, bus.WrRegDSrc, bus.ExtSel,
                bus.RegDst, bus.PCSrc, bus.ALUOp};

  task automatic check(string nm, logic [17:0] a, logic [17:0] e, logic [17:0] m);
    checks++;
    if ((a & m) !== (e & m)) begin
      failures++;
      $display("FAIL %s actual=%b required=%b mask=%b", nm, a, e, m);
    end
  endtask

  // en = {PCWre,IRWre,RegWre,mRD,mWR,halted}; sv = {ALUSrcA,ALUSrcB,DBDataSrc,WrRegDSrc,ExtSel,RegDst,PCSrc,ALUOp}
  task automatic step(string nm, logic rn, logic [5:0] op, logic z, logic s,
                      logic [5:0] en, logic [11:0] sv, logic [11:0] sm);
    @(posedge clk);
    #1;
    rst_n = rn;
    bus.opcode = op;
    bus.zero = z;
    bus.sign = s;
    q.push_back('{nm, {en, sv}, {6'h3f, sm}});
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, act, e.v, e.m);
    end
  end

  initial begin
    bus.opcode = 6'b000000;
    bus.zero = 0;
    bus.sign = 0;
    step("reset", 0, 6'b000000, 0, 0, 6'b000000, 12'h000, 12'hfff);
    step("add_if", 1, 6'b000000, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("add_id", 1, 6'b000000, 0, 0, 6'b000000, 12'h000, 12'h000);
    step("add_exe", 1, 6'b000000, 0, 0, 6'b000000, 12'b0_0_0_0_0_00_00_000, m_a | m_b | m_op);
    step("add_wb", 1, 6'b000000, 0, 0, 6'b101000, 12'b0_0_0_1_0_10_00_000, m_db | m_wr | m_dst | m_pc);
    step("lw_if", 1, 6'b110001, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("lw_id", 1, 6'b110001, 0, 0, 6'b000000, 12'h000, 12'h000);
    step("lw_exe", 1, 6'b110001, 0, 0, 6'b000000, 12'b0_1_0_0_1_00_00_000, m_b | m_ext | m_op);
    step("lw_mem", 1, 6'b110001, 0, 0, 6'b000100, 12'h000, 12'h000);
    step("lw_wb", 1, 6'b110001, 0, 0, 6'b101100, 12'b0_0_1_1_0_01_00_000, m_db | m_wr | m_dst | m_pc);
    step("beq1_if", 1, 6'b110100, 1, 0, 6'b010000, 12'h000, 12'h000);
    step("beq1_id", 1, 6'b110100, 1, 0, 6'b000000, 12'h000, 12'h000);
    step("beq1_exe", 1, 6'b110100, 1, 0, 6'b100000, 12'b0_0_0_0_0_00_01_001, m_pc | m_op);
    step("beq0_if", 1, 6'b110100, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("beq0_id", 1, 6'b110100, 0, 0, 6'b000000, 12'h000, 12'h000);
    step("beq0_exe", 1, 6'b110100, 0, 0, 6'b100000, 12'b0_0_0_0_0_00_00_001, m_pc | m_op);
    step("bne_if", 1, 6'b110101, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("bne_id", 1, 6'b110101, 0, 0, 6'b000000, 12'h000, 12'h000);
    step("bne_exe", 1, 6'b110101, 0, 0, 6'b100000, 12'b0_0_0_0_0_00_01_001, m_pc | m_op);
    step("bltz_if", 1, 6'b110110, 0, 1, 6'b010000, 12'h000, 12'h000);
    step("bltz_id", 1, 6'b110110, 0, 1, 6'b000000, 12'h000, 12'h000);
    step("bltz_exe", 1, 6'b110110, 0, 1, 6'b100000, 12'b0_0_0_0_0_00_01_110, m_pc | m_op);
    step("jal_if", 1, 6'b111010, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("jal_id", 1, 6'b111010, 0, 0, 6'b101000, 12'b0_0_0_0_0_00_11_000, m_wr | m_dst | m_pc);
    step("jr_if", 1, 6'b111001, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("jr_id", 1, 6'b111001, 0, 0, 6'b100000, 12'b0_0_0_0_0_00_10_000, m_pc);
    step("j_if", 1, 6'b111000, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("j_id", 1, 6'b111000, 0, 0, 6'b100000, 12'b0_0_0_0_0_00_11_000, m_pc);
    step("ori_if", 1, 6'b010010, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("ori_id", 1, 6'b010010, 0, 0, 6'b000000, 12'h000, 12'h000);
    step("ori_exe", 1, 6'b010010, 0, 0, 6'b000000, 12'b0_1_0_0_0_00_00_011, m_b | m_ext | m_op);
    step("ori_wb", 1, 6'b010010, 0, 0, 6'b101000, 12'b0_0_0_1_0_01_00_000, m_db | m_wr | m_dst | m_pc);
    step("sll_if", 1, 6'b011000, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("sll_id", 1, 6'b011000, 0, 0, 6'b000000, 12'h000, 12'h000);
    step("sll_exe", 1, 6'b011000, 0, 0, 6'b000000, 12'b1_0_0_0_0_00_00_010, m_a | m_b | m_op);
    step("sll_wb", 1, 6'b011000, 0, 0, 6'b101000, 12'b0_0_0_1_0_10_00_000, m_dst | m_pc | m_wr);
    step("sltiu_if", 1, 6'b100111, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("sltiu_id", 1, 6'b100111, 0, 0, 6'b000000, 12'h000, 12'h000);
    step("sltiu_exe", 1, 6'b100111, 0, 0, 6'b000000, 12'b0_1_0_0_0_00_00_101, m_b | m_ext | m_op);
    step("sltiu_wb", 1, 6'b100111, 0, 0, 6'b101000, 12'b0_0_0_1_0_01_00_000, m_dst | m_pc);
    step("sw_if", 1, 6'b110000, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("sw_id", 1, 6'b110000, 0, 0, 6'b000000, 12'h000, 12'h000);
    step("sw_exe", 1, 6'b110000, 0, 0, 6'b000000, 12'b0_1_0_0_1_00_00_000, m_b | m_ext | m_op);
    step("sw_mem", 1, 6'b110000, 0, 0, 6'b100010, 12'b0_0_0_0_0_00_00_000, m_pc);
    step("sw2_if", 1, 6'b110000, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("sw2_id", 1, 6'b110000, 0, 0, 6'b000000, 12'h000, 12'h000);
    step("sw2_exe", 1, 6'b110000, 0, 0, 6'b000000, 12'h000, 12'h000);
    step("sw2_mem", 1, 6'b110000, 0, 0, 6'b100010, 12'h000, 12'h000);
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    check("sw2_async_reset", act, 18'h0, 18'h3ffff);
    step("sw2_in_reset", 0, 6'b110000, 0, 0, 6'b000000, 12'h000, 12'hfff);
    step("undef_if", 1, 6'b101010, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("undef_id", 1, 6'b101010, 0, 0, 6'b100000, 12'b0_0_0_0_0_00_00_000, m_pc);
    step("halt_if", 1, 6'b111111, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("halt_id", 1, 6'b111111, 0, 0, 6'b000000, 12'h000, 12'h000);
    for (int i = 0; i < 20; i++)
      step($sformatf("halt_hold%0d", i), 1, 6'b111111, 0, 0, 6'b000001, 12'h000, 12'h000);
    step("halt_reset", 0, 6'b111111, 0, 0, 6'b000000, 12'h000, 12'hfff);
    step("post_halt_if", 1, 6'b000000, 0, 0, 6'b010000, 12'h000, 12'h000);
    step("post_halt_id", 1, 6'b000000, 0, 0, 6'b000000, 12'h000, 12'h000);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
